// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic-array matrix-multiply controller.
package sa_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam bit SEL_A = 1'b0;
  localparam bit SEL_B = 1'b1;

  // Accumulator width that holds N products of two DW-bit operands without overflow.
  function automatic int acc_width(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/sa_mm_ctrl_if.sv
// Operand-write, result-read and array-side signals of the systolic-array controller.
interface sa_mm_ctrl_if #(
  parameter int N  = 8,
  parameter int DW = 8,
  parameter int AW = 2 * DW + $clog2(N)
);
  localparam int IW = $clog2(N);

  logic              wr_valid;
  logic              wr_ready;
  logic              wr_sel;
  logic [IW-1:0]     wr_row;
  logic [IW-1:0]     wr_col;
  logic [DW-1:0]     wr_data;
  logic              start;
  logic              busy;
  logic              done;
  logic              err;
  logic              rd_req;
  logic [IW-1:0]     rd_row;
  logic [IW-1:0]     rd_col;
  logic              rd_valid;
  logic [AW-1:0]     rd_data;
  logic              sa_en;
  logic              sa_valid;
  logic [IW-1:0]     sa_idx;
  logic [N*DW-1:0]   sa_a;
  logic [N*DW-1:0]   sa_b;
  logic [N*N*AW-1:0] sa_y;
  logic              sa_y_valid;

  modport master (
    output wr_valid, wr_sel, wr_row, wr_col, wr_data, start,
    output rd_req, rd_row, rd_col, sa_y, sa_y_valid,
    input  wr_ready, busy, done, err, rd_valid, rd_data,
    input  sa_en, sa_valid, sa_idx, sa_a, sa_b
  );

  modport slave (
    input  wr_valid, wr_sel, wr_row, wr_col, wr_data, start,
    input  rd_req, rd_row, rd_col, sa_y, sa_y_valid,
    output wr_ready, busy, done, err, rd_valid, rd_data,
    output sa_en, sa_valid, sa_idx, sa_a, sa_b
  );

endinterface

// File: rtl/sa_operand_bank.sv
// One N x N operand bank: single write port, combinational slice read of
// column idx (COL_SLICE=1, lane i = M[i][idx]) or row idx (COL_SLICE=0, lane j = M[idx][j]).
module sa_operand_bank #(
  parameter int N         = 8,
  parameter int DW        = 8,
  parameter bit COL_SLICE = 1'b1
) (
  input  logic                   CLK,
  input  logic                   we,
  input  logic [$clog2(N)-1:0]   row,
  input  logic [$clog2(N)-1:0]   col,
  input  logic [DW-1:0]          data,
  input  logic [$clog2(N)-1:0]   idx,
  output logic [N*DW-1:0]        slice
);

  logic [DW-1:0] mem [N][N];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[row][col] <= data;
    end
  end

  for (genvar l = 0; l < N; l++) begin : g_lane
    if (COL_SLICE) begin : g_col
      assign slice[l*DW +: DW] = mem[l][idx];
    end else begin : g_row
      assign slice[l*DW +: DW] = mem[idx][l];
    end
  end

endmodule

// File: rtl/sa_mm_ctrl.sv
// Systolic-array controller: buffers A/B, feeds N steps into the array, captures
// the N x N result on completion (or flags a drain timeout), and serves result reads.
module sa_mm_ctrl
  import sa_pkg::*;
#(
  parameter int N       = 8,
  parameter int DW      = 8,
  parameter int AW      = acc_width(DW, N),
  parameter int TIMEOUT = 4 * N
) (
  input  logic        CLK,
  input  logic        RST,
  sa_mm_ctrl_if.slave bus
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t            state;
  logic [1:0]        loaded;
  logic [1:0]        lock;
  logic [IW-1:0]     k;
  logic [IW-1:0]     feed_idx;
  logic [CW-1:0]     cnt;
  logic [N*N*AW-1:0] res;
  logic [AW-1:0]     res_el [N][N];
  logic [N*DW-1:0]   slice_a, slice_b, sa_a_q, sa_b_q;
  logic [AW-1:0]     rd_data_q;
  logic              busy_q, done_q, err_q, rd_valid_q, sa_en_q, sa_valid_q;
  logic              wr_fire, last_elem;

  assign bus.wr_ready = ((state == IDLE) || (state == HOLD)) && !lock[bus.wr_sel];
  assign wr_fire      = bus.wr_valid && bus.wr_ready;
  assign last_elem    = (bus.wr_row == IW'(N - 1)) && (bus.wr_col == IW'(N - 1));

  // Banks are read one step ahead so sa_a/sa_b can be registered outputs.
  assign feed_idx = (state == FEED) ? k + IW'(1) : '0;

  sa_operand_bank #(.N(N), .DW(DW), .COL_SLICE(1'b1)) u_bank_a (
    .CLK   (CLK),
    .we    (wr_fire && (bus.wr_sel == SEL_A)),
    .row   (bus.wr_row),
    .col   (bus.wr_col),
    .data  (bus.wr_data),
    .idx   (feed_idx),
    .slice (slice_a)
  );

  sa_operand_bank #(.N(N), .DW(DW), .COL_SLICE(1'b0)) u_bank_b (
    .CLK   (CLK),
    .we    (wr_fire && (bus.wr_sel == SEL_B)),
    .row   (bus.wr_row),
    .col   (bus.wr_col),
    .data  (bus.wr_data),
    .idx   (feed_idx),
    .slice (slice_b)
  );

  for (genvar i = 0; i < N; i++) begin : g_res_row
    for (genvar j = 0; j < N; j++) begin : g_res_col
      assign res_el[i][j] = res[(i*N+j)*AW +: AW];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= IDLE;
      loaded     <= '0;
      lock       <= '0;
      k          <= '0;
      cnt        <= '0;
      res        <= '0;
      sa_a_q     <= '0;
      sa_b_q     <= '0;
      rd_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      sa_en_q    <= 1'b0;
      sa_valid_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      if (wr_fire && last_elem) begin
        loaded[bus.wr_sel] <= 1'b1;
        lock[bus.wr_sel]   <= 1'b1;
      end
      case (state)
        IDLE, HOLD: begin
          if ((state == HOLD) && bus.rd_req) begin
            rd_valid_q <= 1'b1;
            rd_data_q  <= res_el[bus.rd_row][bus.rd_col];
          end
          // loaded is the pre-write value, so a completing write cannot satisfy this start.
          if (bus.start) begin
            if (&loaded) begin
              state      <= FEED;
              loaded     <= '0;
              k          <= '0;
              busy_q     <= 1'b1;
              sa_en_q    <= 1'b1;
              sa_valid_q <= 1'b1;
              sa_a_q     <= slice_a;
              sa_b_q     <= slice_b;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        FEED: begin
          if (k == IW'(N - 1)) begin
            state      <= DRAIN;
            k          <= '0;
            cnt        <= '0;
            sa_valid_q <= 1'b0;
            sa_a_q     <= '0;
            sa_b_q     <= '0;
          end else begin
            k      <= k + IW'(1);
            sa_a_q <= slice_a;
            sa_b_q <= slice_b;
          end
        end
        DRAIN: begin
          if (bus.sa_y_valid) begin
            res     <= bus.sa_y;
            done_q  <= 1'b1;
            lock    <= '0;
            busy_q  <= 1'b0;
            sa_en_q <= 1'b0;
            state   <= HOLD;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            lock    <= '0;
            busy_q  <= 1'b0;
            sa_en_q <= 1'b0;
            state   <= HOLD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.sa_en    = sa_en_q;
  assign bus.sa_valid = sa_valid_q;
  assign bus.sa_idx   = k;
  assign bus.sa_a     = sa_a_q;
  assign bus.sa_b     = sa_b_q;

endmodule
